// File: rtl/hwag_div_scheduler.sv
// Round-robin scheduler that shares one sequential divider between NCH ignition channels.
// Optional WAIT watchdog is compiled in with `define HWAG_DIV_SCHED_TIMEOUT_EN.
module hwag_div_scheduler #(
  parameter int WIDTH   = 24,
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] dividend_bus,
  input  logic [NCH*WIDTH-1:0] divider_bus,
  output logic [NCH-1:0]       done,
  output logic [WIDTH-1:0]     res_data,
  output logic [CHW-1:0]       res_ch,
  output logic                 busy,
  output logic                 err,
  output logic                 div_start,
  output logic [WIDTH-1:0]     div_dividend,
  output logic [WIDTH-1:0]     div_divider,
  input  logic [WIDTH-1:0]     div_result,
  input  logic                 div_rdy
);

  typedef enum logic [2:0] {IDLE, START, WAIT, ZDIV, DONE} state_t;

  state_t           state, next_state;
  logic [NCH-1:0]   pending, grant_mask;
  logic [CHW-1:0]   ptr, grant_ch, cur_ch, rr_idx;
  logic             grant_found, grant, timeout_hit;
  logic [WIDTH-1:0] sel_dividend, sel_divider;

  // First pending channel at or after ptr, wrapping modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    rr_idx      = '0;
    for (int j = 0; j < NCH; j++) begin
      rr_idx = CHW'((int'(ptr) + j) % NCH);
      if (!grant_found && pending[rr_idx]) begin
        grant_found = 1'b1;
        grant_ch    = rr_idx;
      end
    end
  end

  assign grant        = (state == IDLE) && grant_found;
  assign grant_mask   = grant ? (NCH'(1) << grant_ch) : '0;
  assign sel_dividend = dividend_bus[int'(grant_ch)*WIDTH +: WIDTH];
  assign sel_divider  = divider_bus[int'(grant_ch)*WIDTH +: WIDTH];

`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end

  // Hit on the TIMEOUT-th WAIT cycle so done lands in the following cycle.
  assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    done       = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (grant_found) next_state = (sel_divider == '0) ? ZDIV : START;
      START: begin
        div_start  = 1'b1;
        next_state = WAIT;
      end
      WAIT:    if (div_rdy || timeout_hit) next_state = DONE;
      ZDIV:    next_state = DONE;
      DONE: begin
        done       = NCH'(1) << cur_ch;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A req landing in its own grant cycle re-arms pending, so it is served again later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      ptr          <= '0;
      cur_ch       <= '0;
      res_data     <= '0;
      res_ch       <= '0;
      err          <= 1'b0;
      div_dividend <= '0;
      div_divider  <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | req;
      err     <= 1'b0;
      if (grant) begin
        cur_ch       <= grant_ch;
        div_dividend <= sel_dividend;
        div_divider  <= sel_divider;
      end
      if (state == WAIT && div_rdy) begin
        res_data <= div_result;
        res_ch   <= cur_ch;
      end else if ((state == WAIT && timeout_hit) || state == ZDIV) begin
        res_data <= '1;
        res_ch   <= cur_ch;
        err      <= 1'b1;
      end
      if (state == DONE) ptr <= (cur_ch == CHW'(NCH - 1)) ? '0 : cur_ch + 1'b1;
    end
  end

endmodule

// File: tb/tb_hwag_div_scheduler.sv
// Scoreboard bench for hwag_div_scheduler: expected services are queued at issue time
// and a monitor pops/compares on every done pulse; a behavioural divider answers div_start.
module tb_hwag_div_scheduler;
  localparam int WIDTH   = 24;
  localparam int NCH     = 4;
  localparam int CHW     = 2;
  localparam int TIMEOUT = 64;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] res;
    logic             err_f;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] dividend_bus, divider_bus;
  logic [NCH-1:0]       done;
  logic [WIDTH-1:0]     res_data;
  logic [CHW-1:0]       res_ch;
  logic                 busy, err, div_start;
  logic [WIDTH-1:0]     div_dividend, div_divider, div_result;
  logic                 div_rdy;

  logic [WIDTH-1:0] dvd [NCH];
  logic [WIDTH-1:0] dvs [NCH];
  logic             stub_rdy, man_rdy, stub_hold;
  logic [WIDTH-1:0] stub_result, man_result, sa, sb;
  int               stub_lat, lat;

  exp_t exp_q[$];
  int   checks = 0, passed = 0;
  int   starts_seen = 0, exp_starts = 0, model_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      dividend_bus[i*WIDTH +: WIDTH] = dvd[i];
      divider_bus[i*WIDTH +: WIDTH]  = dvs[i];
    end
  end

  assign div_rdy    = stub_rdy | man_rdy;
  assign div_result = man_rdy ? man_result : stub_result;

  hwag_div_scheduler #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .dividend_bus(dividend_bus), .divider_bus(divider_bus),
    .done(done), .res_data(res_data), .res_ch(res_ch),
    .busy(busy), .err(err), .div_start(div_start),
    .div_dividend(div_dividend), .div_divider(div_divider),
    .div_result(div_result), .div_rdy(div_rdy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference: quotient, or all-ones plus err for a zero divisor; rotation resumes after the served channel.
  function automatic void pushExp(input int c);
    exp_t e;
    e.ch = c;
    if (dvs[c] == '0) begin
      e.res   = ALL1;
      e.err_f = 1'b1;
    end else begin
      e.res   = dvd[c] / dvs[c];
      e.err_f = 1'b0;
      exp_starts++;
    end
    exp_q.push_back(e);
    model_ptr = (c + 1) % NCH;
  endfunction

  task automatic applyStimulus(input logic [NCH-1:0] mask, input int ncyc);
    @(negedge clk) req = mask;
    repeat (ncyc) @(negedge clk);
    req = '0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_done", done, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_ch", res_ch, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_div_start", div_start, 0);
    checkOutput("rst_div_dividend", div_dividend, 0);
    checkOutput("rst_div_divider", div_divider, 0);
  endtask

  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_ptr = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (div_start) starts_seen++;
    if (done != '0) begin
      if (exp_q.size() == 0) checkOutput("unexpected_done", done, 0);
      else begin
        e = exp_q.pop_front();
        checkOutput("done_vec", done, 32'(1) << e.ch);
        checkOutput("res_ch", res_ch, e.ch);
        checkOutput("res_data", res_data, e.res);
        checkOutput("err", err, e.err_f);
      end
    end else if (err) checkOutput("err_without_done", err, 0);
  end

  // Behavioural divider: answers each div_start after a fixed or random latency.
  initial begin
    stub_rdy    = 1'b0;
    stub_result = '0;
    forever begin
      @(posedge clk); #1;
      if (div_start && !stub_hold) begin
        sa  = div_dividend;
        sb  = div_divider;
        lat = (stub_lat != 0) ? stub_lat : $urandom_range(1, 20);
        repeat (lat) @(negedge clk);
        stub_result = (sb != '0) ? sa / sb : ALL1;
        stub_rdy    = 1'b1;
        @(posedge clk); #1;
        checkOutput("done_after_rdy", done != '0, 1);
        stub_rdy = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] mask;
    int p, c, n, bad;
    req = '0; stub_hold = 1'b0; stub_lat = 0;
    man_rdy = 1'b0; man_result = '0;
    for (int i = 0; i < NCH; i++) begin
      dvd[i] = '0;
      dvs[i] = 24'd1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    @(negedge clk) rst = 1'b0;

    // Single request with a 24-cycle divider.
    dvd[1] = 24'd50000; dvs[1] = 24'd1000; stub_lat = 24;
    pushExp(1);
    applyStimulus(4'b0010, 1);
    @(posedge clk); #1;
    checkOutput("start_latency", div_start, 1);
    waitDrain(200);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("busy_after_single", busy, 0);

    // Round-robin from reset, ch0 re-requested during ch1 service.
    doReset();
    stub_lat = 0;
    for (int i = 0; i < NCH; i++) begin
      dvd[i] = WIDTH'($urandom);
      dvs[i] = WIDTH'($urandom_range(1, 5000));
    end
    for (int i = 0; i < NCH; i++) pushExp(i);
    applyStimulus(4'b1111, 1);
    n = 0;
    while (exp_q.size() > 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) checkOutput("rr_first_timeout", n, 0);
    pushExp(0);
    applyStimulus(4'b0001, 1);
    waitDrain(1000);

    // Collision with the grant cycle, then a collapsing third request.
    dvd[2] = WIDTH'($urandom); dvs[2] = WIDTH'($urandom_range(1, 300));
    pushExp(2);
    pushExp(2);
    applyStimulus(4'b0100, 2);
    applyStimulus(4'b0100, 1);
    waitDrain(500);

    // Zero divider on ch3.
    dvd[3] = WIDTH'($urandom); dvs[3] = '0;
    pushExp(3);
    @(negedge clk) req = 4'b1000;
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1;
    checkOutput("zdiv_quiet_k1", {div_start, done}, 0);
    @(posedge clk); #1;
    checkOutput("zdiv_done_k2", done, 4'b1000);
    checkOutput("zdiv_err_k2", err, 1);
    waitDrain(50);

    // Random batches against the round-robin reference.
    for (int it = 0; it < 25; it++) begin
      mask = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int i = 0; i < NCH; i++) begin
        dvd[i] = WIDTH'($urandom);
        if ($urandom_range(0, 7) == 0) dvs[i] = '0;
        else if ($urandom_range(0, 1) == 0) dvs[i] = WIDTH'($urandom_range(1, 4096));
        else dvs[i] = WIDTH'($urandom);
      end
      p = model_ptr;
      for (int j = 0; j < NCH; j++) begin
        c = (p + j) % NCH;
        if (mask[c]) pushExp(c);
      end
      applyStimulus(mask, 1);
      waitDrain(2000);
    end

    // Reset while waiting on the divider, then a stale rdy.
    stub_hold = 1'b1;
    dvd[0] = 24'd1234; dvs[0] = 24'd7;
    exp_starts++;
    applyStimulus(4'b0001, 1);
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_ptr = 0;
    @(negedge clk) begin
      man_result = 24'h012345;
      man_rdy    = 1'b1;
    end
    @(negedge clk) man_rdy = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done != '0 || err || busy) bad++;
    end
    checkOutput("post_reset_quiet", bad, 0);
    checkReset();

    // Divider never answers.
    dvd[1] = 24'd999; dvs[1] = 24'd3;
    exp_starts++;
`ifdef HWAG_DIV_SCHED_TIMEOUT_EN
    exp_q.push_back('{1, ALL1, 1'b1});
    applyStimulus(4'b0010, 1);
    @(posedge clk); #1;
    checkOutput("to_start", div_start, 1);
    repeat (64) @(posedge clk);
    #1;
    checkOutput("to_not_early", done, 0);
    @(posedge clk); #1;
    checkOutput("to_done_65", done, 4'b0010);
    checkOutput("to_err", err, 1);
    checkOutput("to_res", res_data, ALL1);
    waitDrain(10);
`else
    applyStimulus(4'b0010, 1);
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (!busy) bad++;
    end
    checkOutput("no_timeout_busy", bad, 0);
    doReset();
`endif

    repeat (3) @(posedge clk);
    #2;
    checkOutput("div_start_count", starts_seen, exp_starts);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
